aes_coproc_ctrl: RTL and testbench

Sequencer that shares one AES encrypt core and one AES decrypt core (128-bit, common key/data inputs) with the UART command decoder. It accepts command frames: key load, encrypt, decrypt, read last result. It drives the core start strobes, waits for the result-valid with a timeout, latches the result, and returns a response over a valid/ready handshake toward the UART TX framer. It replaces the ad-hoc start/latch logic in the top-level decoder.

---
 rtl/aes_coproc_pkg.sv | 24 ++
 rtl/op_timer.sv | 24 ++
 rtl/aes_coproc_ctrl.sv | 136 +++++++++++++
 tb/tb_aes_coproc_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_coproc_pkg.sv
// Shared encodings for the AES coprocessor sequencer.
package aes_coproc_pkg;

    typedef enum logic [1:0] {
        OP_KEY  = 2'd0,
        OP_ENC  = 2'd1,
        OP_DEC  = 2'd2,
        OP_READ = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_NOKEY   = 2'd2
    } status_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/op_timer.sv
// Wait-phase cycle counter; expired flags the last permitted cycle.
module op_timer #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_BITS        = 9
) (
    input  logic clk,
    input  logic nreset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [TO_BITS-1:0] count;

    // Count cycles spent waiting; clear wins over enable.
    always_ff @(posedge clk) begin
        if (!nreset)    count <= '0;
        else if (clear) count <= '0;
        else if (en)    count <= count + TO_BITS'(1);
    end

    assign expired = (count == TO_BITS'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/aes_coproc_ctrl.sv
// Sequencer sharing one AES encrypt and one decrypt core with the UART
// command decoder: key load, encrypt, decrypt, read-back of last result.
module aes_coproc_ctrl
    import aes_coproc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_BITS        = 9
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [127:0] cmd_data,
    output logic [127:0] aes_key,
    output logic [127:0] aes_data,
    output logic         enc_start,
    output logic         dec_start,
    input  logic         enc_valid,
    input  logic [127:0] enc_res,
    input  logic         dec_valid,
    input  logic [127:0] dec_res,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic [1:0]   rsp_status,
    output logic         key_loaded,
    output logic         busy
);

    state_e       state, state_n;
    logic         sel_dec;
    logic         timer_clr, timer_en, expired;
    logic         accept, sel_valid;
    logic [127:0] sel_res, result_reg;

    // Only the core chosen at acceptance may complete the operation.
    assign sel_valid = sel_dec ? dec_valid : enc_valid;
    assign sel_res   = sel_dec ? dec_res   : enc_res;
    assign accept    = cmd_valid && (state == ST_IDLE);

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign enc_start = (state == ST_START) && !sel_dec;
    assign dec_start = (state == ST_START) &&  sel_dec;

    op_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_BITS       (TO_BITS)
    ) u_timer (
        .clk    (clk),
        .nreset (nreset),
        .clear  (timer_clr),
        .en     (timer_en),
        .expired(expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!nreset) state <= ST_IDLE;
        else         state <= state_n;
    end

    // Next-state and timer control; a result on the expiry cycle still wins.
    always_comb begin
        state_n   = state;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_KEY:         state_n = ST_IDLE;
                        OP_ENC, OP_DEC: state_n = key_loaded ? ST_START : ST_RESP;
                        default:        state_n = ST_RESP;
                    endcase
                end
            end
            ST_START: begin
                timer_clr = 1'b1;
                state_n   = ST_WAIT;
            end
            ST_WAIT: begin
                if (sel_valid || expired) state_n = ST_RESP;
                else                      timer_en = 1'b1;
            end
            default: begin
                if (rsp_ready) state_n = ST_IDLE;
            end
        endcase
    end

    // Datapath: key/data latched at acceptance and held for the whole operation.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            aes_key    <= '0;
            aes_data   <= '0;
            result_reg <= '0;
            key_loaded <= 1'b0;
            sel_dec    <= 1'b0;
            rsp_data   <= '0;
            rsp_status <= ST_OK;
        end else if (accept) begin
            case (cmd_op)
                OP_KEY: begin
                    aes_key    <= cmd_data;
                    key_loaded <= 1'b1;
                end
                OP_ENC, OP_DEC: begin
                    if (key_loaded) begin
                        aes_data <= cmd_data;
                        sel_dec  <= (cmd_op == OP_DEC);
                    end else begin
                        rsp_data   <= '0;
                        rsp_status <= ST_NOKEY;
                    end
                end
                default: begin
                    rsp_data   <= result_reg;
                    rsp_status <= ST_OK;
                end
            endcase
        end else if (state == ST_WAIT) begin
            if (sel_valid) begin
                result_reg <= sel_res;
                rsp_data   <= sel_res;
                rsp_status <= ST_OK;
            end else if (expired) begin
                rsp_data   <= '0;
                rsp_status <= ST_TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_aes_coproc_ctrl.sv
// Randomised scoreboard bench for aes_coproc_ctrl with behavioural AES core models.
module tb_aes_coproc_ctrl;

    localparam int T = 16;
    localparam logic [1:0] OPK = 2'd0, OPE = 2'd1, OPD = 2'd2, OPR = 2'd3;
    localparam logic [1:0] S_OK = 2'd0, S_TO = 2'd1, S_NK = 2'd2;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk, nreset;
    logic         cmd_valid, cmd_ready;
    logic [1:0]   cmd_op;
    logic [127:0] cmd_data, aes_key, aes_data;
    logic         enc_start, dec_start, enc_valid, dec_valid;
    logic [127:0] enc_res, dec_res, rsp_data;
    logic         rsp_valid, rsp_ready, key_loaded, busy;
    logic [1:0]   rsp_status;

    aes_coproc_ctrl #(.TIMEOUT_CYCLES(T), .TO_BITS(5)) dut (
        .clk(clk), .nreset(nreset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .aes_key(aes_key), .aes_data(aes_data),
        .enc_start(enc_start), .dec_start(dec_start),
        .enc_valid(enc_valid), .enc_res(enc_res), .dec_valid(dec_valid), .dec_res(dec_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .key_loaded(key_loaded), .busy(busy)
    );

    typedef struct {
        logic [127:0] data;
        logic [1:0]   status;
        int           cyc;
    } exp_t;

    exp_t sbq[$];
    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int enc_pulses = 0, dec_pulses = 0, rsp_done = 0;
    int plan_d = 0, plan_spur = 0, enc_tgt = -1, dec_tgt = -1, hold_req = 0;
    bit rand_ready = 0;
    logic [127:0] cap_key = '0, cap_data = '0;
    bit cap_dec = 0;
    // reference model state
    bit ref_kl = 0;
    logic [127:0] ref_key = '0, ref_res = '0;

    function automatic logic [127:0] core_fn(bit dec, logic [127:0] k, logic [127:0] d);
        if (!dec && k == K0 && d == P0) return V0;
        if (!dec) return d ^ {k[63:0], k[127:64]} ^ 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
        return ~d ^ k ^ {d[7:0], d[127:8]};
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Core models: capture inputs on the start pulse and schedule result valids.
    initial forever begin
        int st, ot;
        @(negedge clk);
        if (enc_start || dec_start) begin
            if (enc_start) enc_pulses++;
            if (dec_start) dec_pulses++;
            cap_key  = aes_key;
            cap_data = aes_data;
            cap_dec  = dec_start;
            st = (plan_d > 0)    ? cyc + plan_d    : -1;
            ot = (plan_spur > 0) ? cyc + plan_spur : -1;
            if (dec_start) begin dec_tgt = st; enc_tgt = ot; end
            else           begin enc_tgt = st; dec_tgt = ot; end
        end
        if (busy && nreset && ((enc_valid && !cap_dec) || (dec_valid && cap_dec))) begin
            chk("key_stable", aes_key, cap_key);
            chk("data_stable", aes_data, cap_data);
        end
    end

    initial begin
        enc_valid = 0; dec_valid = 0; enc_res = '0; dec_res = '0;
        forever begin
            @(posedge clk); #1;
            enc_valid = (cyc == enc_tgt);
            dec_valid = (cyc == dec_tgt);
            enc_res = enc_valid ? core_fn(0, cap_key, cap_data) : {$urandom, $urandom, $urandom, $urandom};
            dec_res = dec_valid ? core_fn(1, cap_key, cap_data) : {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // TX side: directed stalls via hold_req, otherwise random or always ready.
    initial begin
        rsp_ready = 0;
        forever begin
            @(posedge clk); #1;
            if (rsp_valid && hold_req > 0) begin
                rsp_ready = 0;
                hold_req--;
            end else begin
                rsp_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on each new response and checks hold behaviour.
    initial begin
        bit active = 0, prev_hs = 0;
        exp_t e, cur;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                active = 0; prev_hs = 0;
            end else begin
                if (prev_hs) begin
                    chk("ready_after_hs", 128'({cmd_ready, rsp_valid}), 128'(2'b10));
                end
                prev_hs = 0;
                if (rsp_valid) begin
                    if (!active) begin
                        if (sbq.size() == 0) begin
                            chk("unexpected_rsp", 128'(rsp_status), 128'(rsp_status + 2'd1));
                            cur.data = rsp_data; cur.status = rsp_status;
                        end else begin
                            e = sbq.pop_front();
                            chk("rsp_data", rsp_data, e.data);
                            chk("rsp_status", 128'(rsp_status), 128'(e.status));
                            chk("rsp_cycle", 128'(cyc), 128'(e.cyc));
                            cur = e;
                        end
                        active = 1;
                    end else begin
                        chk("hold_data", rsp_data, cur.data);
                        chk("hold_status", 128'(rsp_status), 128'(cur.status));
                    end
                    chk("cmd_ready_in_resp", 128'({cmd_ready, busy}), 128'(2'b01));
                    if (rsp_ready) begin
                        active = 0; prev_hs = 1; rsp_done++;
                    end
                end
            end
        end
    end

    // Issue one command and push its expected response from the reference model.
    task automatic send(logic [1:0] op, logic [127:0] data, int d, int spur, bit push);
        int e0, d0, acc, target, exp_e, exp_d;
        bit ok;
        exp_t e;
        plan_d = d; plan_spur = spur;
        e0 = enc_pulses; d0 = dec_pulses; target = rsp_done + 1;
        exp_e = 0; exp_d = 0;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_op = op; cmd_data = data;
        ok = 0; acc = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; acc = cyc; end
        end
        if (!ok) begin
            chk("accept_timeout", 128'(cmd_ready), 128'(1'b1));
            cmd_valid = 0;
            return;
        end
        e.cyc = acc + 1; e.data = '0; e.status = S_OK;
        if (op == OPR) begin
            e.data = ref_res;
        end else if (op != OPK) begin
            if (!ref_kl) begin
                e.status = S_NK;
            end else begin
                if (op == OPE) exp_e = 1; else exp_d = 1;
                if (d >= 1 && d <= T) begin
                    e.data = core_fn(op == OPD, ref_key, data);
                    e.cyc = acc + 2 + d;
                    ref_res = e.data;
                end else begin
                    e.status = S_TO;
                    e.cyc = acc + 2 + T;
                end
            end
        end
        if (op != OPK && push) sbq.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 0; cmd_op = 2'($urandom); cmd_data = {$urandom, $urandom, $urandom, $urandom};
        if (op == OPK) begin
            ref_kl = 1; ref_key = data;
            @(negedge clk);
            chk("key_latched", aes_key, data);
            chk("key_flags", 128'({key_loaded, rsp_valid, cmd_ready}), 128'(3'b101));
        end else if (push) begin
            for (int k = 0; k < 400 && rsp_done < target; k++) @(negedge clk);
            if (rsp_done < target) chk("rsp_done_timeout", 128'(rsp_done), 128'(target));
            chk("enc_pulses", 128'(enc_pulses - e0), 128'(exp_e));
            chk("dec_pulses", 128'(dec_pulses - d0), 128'(exp_d));
        end
    endtask

    initial begin
        int r, x, d, sp, e0;
        logic [1:0] op;
        nreset = 0; cmd_valid = 0; cmd_op = 0; cmd_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", 128'({cmd_ready, busy, key_loaded, rsp_valid, enc_start, dec_start}),
            128'(6'b100000));
        chk("rst_key", aes_key, '0);
        chk("rst_data", aes_data, '0);
        chk("rst_rsp", {rsp_data[125:0], rsp_status}, '0);
        @(posedge clk); #1 nreset = 1;

        // Directed: no-key, key load, known-answer, timeout, ignored other core, stall.
        send(OPE, P0, 11, 0, 1);
        send(OPK, K0, 0, 0, 1);
        send(OPE, P0, 11, 0, 1);
        send(OPR, '0, 0, 0, 1);
        send(OPD, {4{32'hdeadbeef}}, 0, 0, 1);
        send(OPR, '0, 0, 0, 1);
        hold_req = 10;
        send(OPE, {4{32'h13579bdf}}, 4, 2, 1);
        send(OPE, {4{32'h2468ace0}}, T, 0, 1);
        send(OPD, {4{32'h0badf00d}}, T + 1, 0, 1);

        // Randomised traffic with stalling TX side.
        rand_ready = 1;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            op = (r < 2) ? OPK : (r < 5) ? OPE : (r < 8) ? OPD : OPR;
            x = $urandom_range(0, 9);
            d = (x < 6) ? $urandom_range(1, T) : (x == 6) ? T : (x == 7) ? 0 : (x == 8) ? T + 1 : T + 2;
            sp = $urandom_range(0, 1) ? 0 : ((d >= 1 && d <= T) ? $urandom_range(1, d) : $urandom_range(1, T));
            send(op, {$urandom, $urandom, $urandom, $urandom}, d, sp, 1);
        end

        // Reset in the middle of WAIT; the late core result must vanish.
        rand_ready = 0;
        send(OPK, K0, 0, 0, 1);
        e0 = enc_pulses;
        send(OPE, P0, 12, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("busy_in_wait", 128'(busy), 128'(1'b1));
        @(posedge clk); #1 nreset = 0;
        repeat (2) @(posedge clk);
        #1 nreset = 1;
        ref_kl = 0; ref_key = '0; ref_res = '0;
        @(negedge clk);
        chk("mid_rst_flags", 128'({key_loaded, busy, rsp_valid, cmd_ready}), 128'(4'b0001));
        chk("mid_rst_key", aes_key, '0);
        repeat (20) @(negedge clk);
        chk("late_valid_ignored", 128'({busy, rsp_valid}), 128'(2'b00));
        chk("mid_rst_pulses", 128'(enc_pulses - e0), 128'(1));
        send(OPR, '0, 0, 0, 1);

        rand_ready = 1;
        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, 9);
            op = (r < 2) ? OPK : (r < 5) ? OPE : (r < 8) ? OPD : OPR;
            d = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, T);
            send(op, {$urandom, $urandom, $urandom, $urandom}, d, 0, 1);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 128'(sbq.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
